prf_wb_arbiter: RTL

PRF_WB_ARBITER -- requirements
Module: prf_wb_arbiter

---
 rtl/prf_pkg.sv | 34 +++
 rtl/wb_fifo.sv | 56 +++++
 rtl/prf_wb_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prf_pkg.sv
// Shared writeback entry type and global widths for the PRF writeback arbiter.
// Fallback values apply only when the global defines have not been loaded yet.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 3
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

package prf_pkg;

    localparam int ISSUE_W = `ISSUE_WIDTH;
    localparam int TAG_W   = `PRF_WIDTH;
    localparam int XLEN_W  = `XLEN;

    localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(`ZERO_REG);

    typedef struct packed {
        logic [`PRF_WIDTH-1:0] tag;
        logic [`XLEN-1:0]      data;
    } wb_entry_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-FU circular result buffer: wrapping head/tail pointers plus an occupancy count.
// Reset and flush share one clear path; entry storage is left unreset.
module wb_fifo
    import prf_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [$clog2(BUF_DEPTH):0] count
);

    localparam int PTR_W = idx_w(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    wb_entry_t        mem [BUF_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    assign head  = mem[head_ptr];
    assign count = cnt;

endmodule

// File: rtl/prf_wb_arbiter.sv
// Collects FU results into per-FU buffers and drains up to ISSUE_WIDTH of them
// per cycle, round-robin, into registered PRF write ports.
module prf_wb_arbiter
    import prf_pkg::*;
#(
    parameter int FU_NUM    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [FU_NUM-1:0]       fu_valid,
    input  logic [`PRF_WIDTH-1:0]   fu_tag  [FU_NUM],
    input  logic [`XLEN-1:0]        fu_data [FU_NUM],
    output logic [FU_NUM-1:0]       fu_ready,
    output logic [`ISSUE_WIDTH-1:0] wr_en,
    output logic [`PRF_WIDTH-1:0]   wr_addr [`ISSUE_WIDTH],
    output logic [`XLEN-1:0]        wr_data [`ISSUE_WIDTH]
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int RR_W  = idx_w(FU_NUM);

    logic [CNT_W-1:0]   fifo_cnt  [FU_NUM];
    wb_entry_t          fifo_head [FU_NUM];
    logic [FU_NUM-1:0]  push_p0;
    logic [FU_NUM-1:0]  pop_p0;
    logic [FU_NUM-1:0]  grant_p0;

    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    rr_nxt;
    logic               any_grant;
    int                 scan_dist [FU_NUM];
    int                 scan_rank [FU_NUM];
    int                 last_dist;

    logic [ISSUE_W-1:0] slot_vld_p0;
    wb_entry_t          slot_ent_p0 [ISSUE_W];

    logic [ISSUE_W-1:0] wr_en_p1;
    logic [TAG_W-1:0]   wr_addr_p1 [ISSUE_W];
    logic [XLEN_W-1:0]  wr_data_p1 [ISSUE_W];

    // ---- stage p0: accept into per-FU buffers ----
    for (genvar j = 0; j < FU_NUM; j++) begin : g_fu
        wb_entry_t in_ent;

        // Ready looks only at the registered count, never at this cycle's pop.
        assign fu_ready[j] = (fifo_cnt[j] < CNT_W'(BUF_DEPTH));
        assign in_ent      = '{tag: fu_tag[j], data: fu_data[j]};
        assign push_p0[j]  = fu_valid[j] & fu_ready[j] & (fu_tag[j] != ZERO_TAG) & ~flush;
        assign pop_p0[j]   = grant_p0[j] & ~flush;

        wb_fifo #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .push       (push_p0[j]),
            .push_entry (in_ent),
            .pop        (pop_p0[j]),
            .head       (fifo_head[j]),
            .count      (fifo_cnt[j])
        );
    end

    // ---- stage p0: round-robin scan of non-empty buffers ----
    // Each FU's rank is the number of non-empty FUs ahead of it in scan order;
    // that rank is both the grant test and the output slot it lands in.
    always_comb begin
        grant_p0    = '0;
        slot_vld_p0 = '0;
        any_grant   = 1'b0;
        rr_nxt      = rr_ptr;
        last_dist   = -1;
        for (int k = 0; k < ISSUE_W; k++) begin
            slot_ent_p0[k] = '0;
        end
        for (int j = 0; j < FU_NUM; j++) begin
            scan_dist[j] = (j >= int'(rr_ptr)) ? (j - int'(rr_ptr))
                                               : (j + FU_NUM - int'(rr_ptr));
        end
        for (int j = 0; j < FU_NUM; j++) begin
            scan_rank[j] = 0;
            for (int m = 0; m < FU_NUM; m++) begin
                if (fifo_cnt[m] != '0 && scan_dist[m] < scan_dist[j]) begin
                    scan_rank[j] = scan_rank[j] + 1;
                end
            end
        end
        for (int j = 0; j < FU_NUM; j++) begin
            if (fifo_cnt[j] != '0 && scan_rank[j] < ISSUE_W) begin
                grant_p0[j] = 1'b1;
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int j = 0; j < FU_NUM; j++) begin
                if (grant_p0[j] && scan_rank[j] == k) begin
                    slot_vld_p0[k] = 1'b1;
                    slot_ent_p0[k] = fifo_head[j];
                end
            end
        end
        for (int j = 0; j < FU_NUM; j++) begin
            if (grant_p0[j] && scan_dist[j] > last_dist) begin
                last_dist = scan_dist[j];
                rr_nxt    = RR_W'((j + 1) % FU_NUM);
                any_grant = 1'b1;
            end
        end
    end

    // ---- stage p1: registered PRF write ports ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            wr_en_p1 <= '0;
            for (int k = 0; k < ISSUE_W; k++) begin
                wr_addr_p1[k] <= '0;
                wr_data_p1[k] <= '0;
            end
        end else if (flush) begin
            rr_ptr   <= '0;
            wr_en_p1 <= '0;
        end else begin
            wr_en_p1 <= slot_vld_p0;
            if (any_grant) begin
                rr_ptr <= rr_nxt;
            end
            // Idle slots keep their last address/data to avoid needless toggling.
            for (int k = 0; k < ISSUE_W; k++) begin
                if (slot_vld_p0[k]) begin
                    wr_addr_p1[k] <= slot_ent_p0[k].tag;
                    wr_data_p1[k] <= slot_ent_p0[k].data;
                end
            end
        end
    end

    assign wr_en   = wr_en_p1;
    assign wr_addr = wr_addr_p1;
    assign wr_data = wr_data_p1;

endmodule
